// File: rtl/enc_pkg.sv
// Shared widths and FSM state type for the sequential 16-to-4 priority encoder.
package enc_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDXW  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/lsb_enc16.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit, any-set and
// exactly-one-set flags.
module lsb_enc16
    import enc_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             any,
    output logic             onehot
);

    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    assign any    = |vec;
    assign onehot = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/pri_enc16x4_seq.sv
// Sequential priority encoder: accepts a multi-hot vector and emits the index of
// each set bit in ascending order, one per output handshake.
module pri_enc16x4_seq
    import enc_pkg::*;
#(
    parameter int unsigned WIDTH = enc_pkg::WIDTH,
    parameter int unsigned IDXW  = enc_pkg::IDXW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             zero_det
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic              zero_det_q, zero_det_d;

    logic [IDXW-1:0]   lsb_idx;
    logic              lsb_any;
    logic              lsb_onehot;

    lsb_enc16 u_lsb_enc16 (
        .vec    (pending_q),
        .idx    (lsb_idx),
        .any    (lsb_any),
        .onehot (lsb_onehot)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_det_d = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_idx    = '0;
        out_last   = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        state_d   = SCAN;
                    end else begin
                        zero_det_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                out_valid = lsb_any;
                out_idx   = lsb_idx;
                out_last  = lsb_onehot;
                if (out_ready) begin
                    pending_d = pending_q & ~(WIDTH'(1) << lsb_idx);
                    if (lsb_onehot || !lsb_any) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            zero_det_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            zero_det_q <= zero_det_d;
        end
    end

    assign zero_det = zero_det_q;

endmodule

// File: tb/tb_pri_enc16x4_seq.sv
// Directed self-checking bench for pri_enc16x4_seq with hand-computed expectations.
module tb_pri_enc16x4_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        zero_det;

    int ncmp = 0;
    int nerr = 0;

    pri_enc16x4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_det  (zero_det)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_seq [3];
        logic [15:0] dec;
        exp_seq[0] = 4'd0;
        exp_seq[1] = 4'd4;
        exp_seq[2] = 4'd15;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_idx", 16'(out_idx), 16'd0);
        check("rst_out_last", 16'(out_last), 16'd0);
        check("rst_zero_det", 16'(zero_det), 16'd0);

        // Single bit 0
        in_valid  = 1'b1;
        in_vec    = 16'h0001;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("b0_valid", 16'(out_valid), 16'd1);
        check("b0_idx", 16'(out_idx), 16'd0);
        check("b0_last", 16'(out_last), 16'd1);
        check("b0_in_ready_scan", 16'(in_ready), 16'd0);
        step();
        check("b0_in_ready_after", 16'(in_ready), 16'd1);
        check("b0_valid_after", 16'(out_valid), 16'd0);

        // All ones
        in_valid = 1'b1;
        in_vec   = 16'hFFFF;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("ffff_valid", 16'(out_valid), 16'd1);
            check("ffff_idx", 16'(out_idx), 16'(i));
            check("ffff_last", 16'(out_last), (i == 15) ? 16'd1 : 16'd0);
            step();
        end
        check("ffff_in_ready_after", 16'(in_ready), 16'd1);
        check("ffff_valid_after", 16'(out_valid), 16'd0);

        // 8011 with stall; a new vector offered during SCAN must be ignored
        in_valid  = 1'b1;
        in_vec    = 16'h8011;
        out_ready = 1'b0;
        step();
        in_vec = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 16'(out_valid), 16'd1);
            check("stall_idx", 16'(out_idx), 16'd0);
            check("stall_last", 16'(out_last), 16'd0);
            check("stall_in_ready", 16'(in_ready), 16'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            check("8011_valid", 16'(out_valid), 16'd1);
            check("8011_idx", 16'(out_idx), 16'(exp_seq[j]));
            check("8011_last", 16'(out_last), (j == 2) ? 16'd1 : 16'd0);
            step();
        end
        check("8011_in_ready_after", 16'(in_ready), 16'd1);
        check("8011_valid_after", 16'(out_valid), 16'd0);

        // All-zero vector
        in_valid = 1'b1;
        in_vec   = 16'h0000;
        step();
        in_valid = 1'b0;
        check("zero_det_pulse", 16'(zero_det), 16'd1);
        check("zero_valid", 16'(out_valid), 16'd0);
        check("zero_in_ready", 16'(in_ready), 16'd1);
        step();
        check("zero_det_clear", 16'(zero_det), 16'd0);
        check("zero_valid2", 16'(out_valid), 16'd0);
        check("zero_in_ready2", 16'(in_ready), 16'd1);

        // Round trip through dec4x16 outputs
        for (int k = 0; k < 16; k++) begin
            dec      = 16'd1 << k;
            in_valid = 1'b1;
            in_vec   = dec;
            step();
            in_valid = 1'b0;
            check("rt_valid", 16'(out_valid), 16'd1);
            check("rt_idx", 16'(out_idx), 16'(k));
            check("rt_last", 16'(out_last), 16'd1);
            step();
            check("rt_in_ready", 16'(in_ready), 16'd1);
        end

        // Reset mid-SCAN on 00F0
        in_valid = 1'b1;
        in_vec   = 16'h00F0;
        step();
        in_valid = 1'b0;
        check("f0_idx4", 16'(out_idx), 16'd4);
        step();
        check("f0_idx5", 16'(out_idx), 16'd5);
        check("f0_valid5", 16'(out_valid), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("f0_rst_valid", 16'(out_valid), 16'd0);
        check("f0_rst_in_ready", 16'(in_ready), 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("f0_no_more_valid", 16'(out_valid), 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/pri_enc16x4_seq.md
PRI_ENC16X4_SEQ -- requirements
Module: pri_enc16x4_seq

Interface
REQ-001 Parameter: WIDTH, 16, input vector width; only 16 is supported.
REQ-002 Parameter: IDXW, 4, encoded index width, equal to log2(WIDTH).
REQ-003 Clocking: one clock domain; reset is synchronous and active-high.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  in_vec is presented for acceptance.
REQ-007 in_ready  out  1  block can accept a new vector.
REQ-008 in_vec  in  WIDTH  one-hot or multi-hot request vector (decoder-output format).
REQ-009 out_valid  out  1  out_idx is valid.
REQ-010 out_ready  in  1  consumer accepts out_idx.
REQ-011 out_idx  out  IDXW  index of the current lowest pending set bit.
REQ-012 out_last  out  1  out_idx is the final index of the current vector.
REQ-013 zero_det  out  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-014 The FSM SHALL have two states: IDLE and SCAN.
REQ-015 In IDLE, in_ready=1 and out_valid=0; in SCAN, in_ready=0 and out_valid=1.
REQ-016 Acceptance SHALL be in_valid&&in_ready; accepting a nonzero vector loads the pending register with in_vec and enters SCAN next cycle.
REQ-017 Latency: out_valid SHALL rise exactly one cycle after acceptance.
REQ-018 In SCAN, out_idx SHALL equal the index of the lowest set bit of pending.
REQ-019 out_last SHALL be 1 when pending has exactly one bit set, else 0.
REQ-020 Handshake: out_valid&&out_ready SHALL clear the bit at out_idx in pending.
REQ-021 A handshake with out_last=1 SHALL return the FSM to IDLE, with in_ready=1 on the next cycle.
REQ-022 Indices SHALL be emitted in strictly ascending order, one per handshake, so a vector with N set bits produces exactly N outputs.
REQ-023 While out_valid=1 and out_ready=0, out_idx, out_last and pending SHALL hold stable.
REQ-024 Accepting all-zero in_vec SHALL keep the FSM in IDLE, pulse zero_det high for the following cycle only, and produce no out_valid.
REQ-025 in_vec and in_valid SHALL be ignored while in SCAN; vectors are never overlapped or merged.
REQ-026 Back-to-back operation: after a last handshake, the next vector may be accepted in the following IDLE cycle, giving minimum throughput of N+1 cycles per vector.
REQ-027 For a single-bit vector 1<<k, the single output SHALL be out_idx=k with out_last=1, which makes the block the inverse of dec4x16.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL enter IDLE and clear pending to 0.
REQ-029 Reset values: out_valid=0, out_last=0, out_idx=0, zero_det=0; in_ready=1 from the first cycle after reset.
REQ-030 Reset asserted mid-SCAN SHALL discard all remaining pending bits and emit no further indices.

Structure
REQ-031 A shared package enc_pkg SHALL hold WIDTH, IDXW and the state enumeration (IDLE, SCAN).
REQ-032 Lowest-set-bit detection SHALL be a combinational sub-module lsb_enc16 with outputs idx[3:0], any and onehot (exactly one bit set).
REQ-033 Registers SHALL be limited to the state, the pending register and the zero_det flop.

Verification
REQ-034 in_vec=16'h0001, out_ready=1 -> out_idx=0 with out_last=1 one cycle after acceptance; in_ready=1 on the following cycle.
REQ-035 in_vec=16'hFFFF, out_ready=1 -> out_idx=0..15 on 16 consecutive cycles; out_last=1 only with idx 15.
REQ-036 in_vec=16'h8011 with out_ready held low 3 cycles -> out_idx=0 holds stable; then outputs 0, 4, 15 in that order, last on 15.
REQ-037 in_vec=16'h0000 -> zero_det=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
REQ-038 Round trip: drive each dec4x16 output for in=0..15 -> out_idx equals in, with out_last=1.
REQ-039 in_vec=16'h00F0 with rst=1 after the first handshake -> next cycle out_valid=0, in_ready=1, no index 5/6/7 emitted.
